// File: rtl/ps2_key_event_ctrl_if.sv
// Bus between the PS/2 byte receiver, the key event controller and the event consumer.
// rx side: a byte is taken on the first cycle rx_ready is high; evt side: the head event is popped on any edge where evt_valid && evt_ack.
interface ps2_key_event_ctrl_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       evt_valid;
    logic       evt_ack;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       fifo_full;
    logic       overflow;
    logic       clr_overflow;

    modport slave (
        input  rx_ready, rx_data, evt_ack, clr_overflow,
        output evt_valid, evt_code, evt_ext, evt_break, fifo_full, overflow
    );

    modport master (
        output rx_ready, rx_data, evt_ack, clr_overflow,
        input  evt_valid, evt_code, evt_ext, evt_break, fifo_full, overflow
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Turns PS/2 scan bytes into {ext, break, code} key events queued in a show-ahead FIFO.
// Optional typematic repeat suppression: define PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_key_event_ctrl_if.slave   bus,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXT  = 2'd1;
    localparam logic [1:0] ST_BRK  = 2'd2;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic       rx_ready_q;
    logic       byte_stb;
    logic [1:0] state, state_n;
    logic       ext_f, ext_n;
    logic       is_proto;
    logic       dec_push;
    logic       dec_brk;
    logic       suppress;
    logic [9:0] dec_evt;

    assign byte_stb = bus.rx_ready & ~rx_ready_q;
    assign dec_brk  = (state == ST_BRK);
    assign dec_evt  = {ext_f, dec_brk, bus.rx_data};
    assign dbg_state = state;

    always_comb begin
        is_proto = 1'b0;
        case (bus.rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_proto = 1'b1;
            default: is_proto = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        ext_n    = ext_f;
        dec_push = 1'b0;
        if (byte_stb) begin
            if (bus.rx_data == 8'hE0) begin
                ext_n = 1'b1;
                if (state == ST_IDLE) state_n = ST_EXT;
            end else if (bus.rx_data == 8'hF0) begin
                state_n = ST_BRK;
            end else if (!is_proto) begin
                dec_push = 1'b1;
                ext_n    = 1'b0;
                state_n  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_q <= 1'b0;
            state      <= ST_IDLE;
            ext_f      <= 1'b0;
        end else begin
            rx_ready_q <= bus.rx_ready;
            state      <= state_n;
            ext_f      <= ext_n;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       last_valid;
    logic       last_ext;
    logic [7:0] last_code;
    logic       last_match;

    assign last_match = last_valid && (last_ext == ext_f) && (last_code == bus.rx_data);
    assign suppress   = dec_push && !dec_brk && last_match;

    // A held key repeats its make code; only the first make of a press is queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_valid <= 1'b0;
            last_ext   <= 1'b0;
            last_code  <= 8'h00;
        end else if (dec_push && !suppress) begin
            if (!dec_brk) begin
                last_valid <= 1'b1;
                last_ext   <= ext_f;
                last_code  <= bus.rx_data;
            end else if (last_match) begin
                last_valid <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // One register stage between decode and the FIFO keeps rx_* off every output path.
    logic       push_q;
    logic [9:0] push_evt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q     <= 1'b0;
            push_evt_q <= 10'h000;
        end else begin
            push_q     <= dec_push && !suppress;
            push_evt_q <= dec_evt;
        end
    end

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [AW:0]   count, count_n;
    logic          valid_r, full_r, ovf_r;
    logic [9:0]    head_r, head_n;
    logic          pop, wr_en, drop;

    assign pop   = valid_r & bus.evt_ack;
    assign wr_en = push_q & (~full_r | pop);
    assign drop  = push_q & full_r & ~pop;
    assign rd_n  = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_n = count;
        if (wr_en && !pop)      count_n = count + (AW+1)'(1);
        else if (!wr_en && pop) count_n = count - (AW+1)'(1);
    end

    // When the queue drains to the slot being written, the new event becomes the head directly.
    assign head_n = (wr_en && (wr_ptr == rd_n)) ? push_evt_q : mem[rd_n];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_evt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            head_r  <= 10'h000;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_n;
            count   <= count_n;
            valid_r <= (count_n != '0);
            full_r  <= (count_n == DEPTH_C);
            if (count_n != '0) head_r <= head_n;
            if (drop)                  ovf_r <= 1'b1;
            else if (bus.clr_overflow) ovf_r <= 1'b0;
        end
    end

    assign bus.evt_valid = valid_r;
    assign bus.evt_ext   = head_r[9];
    assign bus.evt_break = head_r[8];
    assign bus.evt_code  = head_r[7:0];
    assign bus.fifo_full = full_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: expected events queued at stimulus, compared by a monitor on pop.
module tb_ps2_key_event_ctrl;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  logic [9:0] exp_q[$];

  ps2_key_event_ctrl_if bus();

  ps2_key_event_ctrl #(.FIFO_DEPTH(4), .AW(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic e, input logic k, input logic [7:0] code);
    exp_q.push_back({e, k, code});
  endtask

  // scoreboard monitor: compares the head at every accepted pop
  always @(negedge clk) begin
    logic [9:0] got;
    logic [9:0] exp_v;
    if (!reset && bus.evt_valid && bus.evt_ack) begin
      got = {bus.evt_ext, bus.evt_break, bus.evt_code};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got %0h expected none", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          errors++;
          $display("FAIL evt_pop: got %0h expected %0h", got, exp_v);
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({name, "_empty"}, bus.evt_valid, 1'b0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.evt_valid, 1'b0);
    check("rst_head", {bus.evt_ext, bus.evt_break, bus.evt_code}, 10'h000);
    check("rst_full", bus.fifo_full, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    bus.evt_ack = 1'b0;
    bus.clr_overflow = 1'b0;
    do_reset();

    // 1: make then break, with decode-to-valid latency
    bus.evt_ack = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C);
    @(negedge clk);
    check("t1_lat_lo", bus.evt_valid, 1'b0);
    @(negedge clk);
    check("t1_lat_hi", bus.evt_valid, 1'b1);
    send_byte(8'hF0);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send_byte(8'h1C);
    wait_drain("t1_drain");

    // 2: extended make/break with FSM tracking
    send_byte(8'hE0);
    @(negedge clk) check("t2_st_ext", dbg_state, 2'd1);
    expect_evt(1'b1, 1'b0, 8'h75);
    send_byte(8'h75);
    @(negedge clk) check("t2_st_idle1", dbg_state, 2'd0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(negedge clk) check("t2_st_brk", dbg_state, 2'd2);
    expect_evt(1'b1, 1'b1, 8'h75);
    send_byte(8'h75);
    @(negedge clk) check("t2_st_idle2", dbg_state, 2'd0);
    wait_drain("t2_drain");

    // 3: held strobe yields one byte; protocol replies discarded
    expect_evt(1'b0, 1'b0, 8'h2A);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    bus.rx_data = 8'h2A;
    repeat (5) @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    send_byte(8'hFA);
    send_byte(8'hAA);
    @(negedge clk) check("t3_st", dbg_state, 2'd0);
    wait_drain("t3_drain");

    // 4: fill, overflow, ordered drain, clear
    bus.evt_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_evt(1'b0, 1'b0, 8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
      repeat (2) @(negedge clk);
      if (i == 2) check("t4_not_full", bus.fifo_full, 1'b0);
      if (i == 3) check("t4_full", bus.fifo_full, 1'b1);
      if (i == 3) check("t4_ovf_lo", bus.overflow, 1'b0);
    end
    check("t4_ovf_hi", bus.overflow, 1'b1);
    check("t4_head", {bus.evt_ext, bus.evt_break, bus.evt_code}, 10'h010);
    bus.evt_ack = 1'b1;
    wait_drain("t4_drain");
    check("t4_ovf_sticky", bus.overflow, 1'b1);
    @(posedge clk); #1 bus.clr_overflow = 1'b1;
    @(posedge clk); #1 bus.clr_overflow = 1'b0;
    @(negedge clk) check("t4_ovf_clr", bus.overflow, 1'b0);

    // 5: full with simultaneous push and pop
    bus.evt_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_evt(1'b0, 1'b0, 8'h30 + 8'(i));
      send_byte(8'h30 + 8'(i));
    end
    repeat (2) @(negedge clk);
    check("t5_full", bus.fifo_full, 1'b1);
    expect_evt(1'b0, 1'b0, 8'h34);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    bus.rx_data = 8'h34;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    bus.evt_ack = 1'b1;
    @(posedge clk); #1 bus.evt_ack = 1'b0;
    @(negedge clk);
    check("t5_still_full", bus.fifo_full, 1'b1);
    check("t5_ovf", bus.overflow, 1'b0);
    check("t5_head", {bus.evt_ext, bus.evt_break, bus.evt_code}, 10'h031);
    bus.evt_ack = 1'b1;
    wait_drain("t5_drain");

    // 6: reset mid-sequence discards the prefix
    send_byte(8'hE0);
    send_byte(8'hF0);
    @(negedge clk) check("t6_st_brk", dbg_state, 2'd2);
    do_reset();
    bus.evt_ack = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h14);
    send_byte(8'h14);
    wait_drain("t6_drain");

    // 6b: typematic repeats
    expect_evt(1'b0, 1'b0, 8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    expect_evt(1'b0, 1'b1, 8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C);
`else
    expect_evt(1'b0, 1'b0, 8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C);
    expect_evt(1'b0, 1'b1, 8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C);
`endif
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    wait_drain("t6_typematic");
    check("t6_ovf", bus.overflow, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
